alu_issue_arbiter: RTL and testbench

- Shares the single clocked ALU between two issue lanes of the superscalar core.
- Per-lane valid/ready request handshake; round-robin grant.
- Drives the ALU input bundle from registers and holds it for the op's latency (MUL is multi-cycle).
- Returns each result with its tag on the granted lane's response port.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/alu_issue_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue arbiter: op-bundle width, one-hot bit
// positions and the issue FSM state type.
package alu_pkg;

    localparam int ALUSIG_W = 13;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 3;
    localparam int ALU_MUL = 4;
    localparam int ALU_CMP = 5;
    localparam int ALU_MOV = 6;
    localparam int ALU_OR  = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_NOT = 9;
    localparam int ALU_LSL = 10;
    localparam int ALU_LSR = 11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Only a clean one-hot MUL takes the long latency; zero or multi-hot bundles do not.
    function automatic logic is_mul_op(input logic [ALUSIG_W-1:0] sig);
        return sig == (ALUSIG_W'(1) << ALU_MUL);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. The pointer names the lane that wins a tie
// and moves to the other lane after every taken grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       upd,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;
    logic [1:0] win;

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr_q ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
        grant = en ? win : 2'b00;
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one clocked ALU between two issue lanes: round-robin accept, holds the
// ALU input bundle for the op latency and returns the result with its tag.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [12:0]         req_alusignals0,
    input  logic [12:0]         req_alusignals1,
    input  logic [15:0]         req_op1_0,
    input  logic [15:0]         req_op1_1,
    input  logic [15:0]         req_op2_0,
    input  logic [15:0]         req_op2_1,
    input  logic [4:0]          req_immx0,
    input  logic [4:0]          req_immx1,
    input  logic                req_isimm0,
    input  logic                req_isimm1,
    input  logic [TAG_W-1:0]    req_tag0,
    input  logic [TAG_W-1:0]    req_tag1,
    output logic [1:0]          resp_valid,
    output logic [15:0]         resp_result,
    output logic [TAG_W-1:0]    resp_tag,
    output logic [12:0]         alu_alusignals,
    output logic [15:0]         alu_op1,
    output logic [15:0]         alu_op2,
    output logic [4:0]          alu_immx,
    output logic                alu_isimmediate,
    input  logic [15:0]         alu_result
);

    localparam int LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int CNT_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lane_q, lane_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [ALUSIG_W-1:0]   sig_q, sig_d;
    logic [15:0]           op1_q, op1_d;
    logic [15:0]           op2_q, op2_d;
    logic [4:0]            immx_q, immx_d;
    logic                  isimm_q, isimm_d;

    logic                  done;
    logic                  free;
    logic                  accept;
    logic                  sel;
    logic [1:0]            grant;

    // The completion cycle doubles as an accept slot so back-to-back ops have no bubble.
    assign done   = (state_q == EXEC) && (cnt_q == '0) && !flush && !reset;
    assign free   = ((state_q == IDLE) || (cnt_q == '0)) && !flush && !reset;
    assign accept = |grant;
    assign sel    = grant[1];

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (free),
        .upd   (accept),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        tag_d   = tag_q;
        sig_d   = sig_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        immx_d  = immx_q;
        isimm_d = isimm_q;
        if (flush) begin
            state_d = IDLE;
            sig_d   = '0;
        end else if (accept) begin
            state_d = EXEC;
            lane_d  = sel;
            tag_d   = sel ? req_tag1        : req_tag0;
            sig_d   = sel ? req_alusignals1 : req_alusignals0;
            op1_d   = sel ? req_op1_1       : req_op1_0;
            op2_d   = sel ? req_op2_1       : req_op2_0;
            immx_d  = sel ? req_immx1       : req_immx0;
            isimm_d = sel ? req_isimm1      : req_isimm0;
            cnt_d   = is_mul_op(sel ? req_alusignals1 : req_alusignals0)
                      ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
        end else if (state_q == EXEC) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
                sig_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lane_q  <= 1'b0;
            tag_q   <= '0;
            sig_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            immx_q  <= '0;
            isimm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            tag_q   <= tag_d;
            sig_q   <= sig_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            immx_q  <= immx_d;
            isimm_q <= isimm_d;
        end
    end

    assign req_ready       = grant;
    assign resp_valid      = done ? (lane_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_result     = done ? alu_result : 16'h0000;
    assign resp_tag        = done ? tag_q : '0;
    assign alu_alusignals  = sig_q;
    assign alu_op1         = op1_q;
    assign alu_op2         = op2_q;
    assign alu_immx        = immx_q;
    assign alu_isimmediate = isimm_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: hand-computed vector table for the directed
// sequences, then random traffic against a timestamp/queue reference model.
module tb_alu_issue_arbiter;

    localparam int TAG_W   = 4;
    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 3;

    logic              clk = 1'b0;
    logic              reset, flush;
    logic [1:0]        req_valid, req_ready;
    logic [12:0]       req_alusignals0, req_alusignals1;
    logic [15:0]       req_op1_0, req_op1_1, req_op2_0, req_op2_1;
    logic [4:0]        req_immx0, req_immx1;
    logic              req_isimm0, req_isimm1;
    logic [TAG_W-1:0]  req_tag0, req_tag1;
    logic [1:0]        resp_valid;
    logic [15:0]       resp_result;
    logic [TAG_W-1:0]  resp_tag;
    logic [12:0]       alu_alusignals;
    logic [15:0]       alu_op1, alu_op2;
    logic [4:0]        alu_immx;
    logic              alu_isimmediate;
    logic [15:0]       alu_result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.TAG_W(TAG_W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alusignals0(req_alusignals0), .req_alusignals1(req_alusignals1),
        .req_op1_0(req_op1_0), .req_op1_1(req_op1_1),
        .req_op2_0(req_op2_0), .req_op2_1(req_op2_1),
        .req_immx0(req_immx0), .req_immx1(req_immx1),
        .req_isimm0(req_isimm0), .req_isimm1(req_isimm1),
        .req_tag0(req_tag0), .req_tag1(req_tag1),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_tag(resp_tag),
        .alu_alusignals(alu_alusignals), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_immx(alu_immx), .alu_isimmediate(alu_isimmediate),
        .alu_result(alu_result)
    );

    // Stand-in ALU: a pure function of the held input bundle.
    function automatic logic [15:0] alu_fn(input logic [12:0] s, input logic [15:0] a,
                                           input logic [15:0] b, input logic [4:0] im,
                                           input logic isim);
        logic [15:0] bb;
        logic [31:0] p;
        bb = isim ? {11'b0, im} : b;
        p  = 32'(a) * 32'(bb);
        case (s)
            13'h0001: return a + bb;
            13'h0008: return a - bb;
            13'h0010: return p[15:0];
            13'h0020: return (a < bb) ? 16'h0001 : 16'h0000;
            13'h0040: return bb;
            13'h0080: return a | bb;
            13'h0100: return a & bb;
            13'h0200: return ~a;
            13'h0400: return a << bb[3:0];
            13'h0800: return a >> bb[3:0];
            default:  return a ^ bb ^ 16'h5a5a;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_alusignals, alu_op1, alu_op2, alu_immx, alu_isimmediate);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: pending response in exp_q {lane,tag,result}, due at done_cyc.
    logic [20:0] exp_q[$];
    int          done_cyc = 0;
    logic        m_ptr = 1'b0;
    logic        m_en  = 1'b0;
    logic [12:0] e_sig = '0;
    logic [15:0] e_op1 = '0, e_op2 = '0;
    logic [4:0]  e_immx = '0;
    logic        e_isimm = 1'b0;

    task automatic step_model();
        logic busy, at_done, blk, ln;
        logic [1:0] w, e_rdy, e_rv;
        logic [15:0] e_res;
        logic [3:0] e_tag;
        logic [12:0] s;
        busy    = exp_q.size() != 0;
        at_done = busy && (cyc == done_cyc);
        blk     = reset || flush;
        case (req_valid)
            2'b01:   w = 2'b01;
            2'b10:   w = 2'b10;
            2'b11:   w = m_ptr ? 2'b10 : 2'b01;
            default: w = 2'b00;
        endcase
        e_rdy = (!blk && (!busy || at_done)) ? w : 2'b00;
        e_rv = 2'b00; e_res = 16'h0; e_tag = 4'h0;
        if (!blk && at_done) begin
            e_rv  = exp_q[0][20] ? 2'b10 : 2'b01;
            e_tag = exp_q[0][19:16];
            e_res = exp_q[0][15:0];
        end
        if (m_en) begin
            chk("m_ready", 32'(req_ready), 32'(e_rdy));
            chk("m_resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("m_resp_result", 32'(resp_result), 32'(e_res));
            chk("m_resp_tag", 32'(resp_tag), 32'(e_tag));
            chk("m_alusig", 32'(alu_alusignals), 32'(e_sig));
            chk("m_op1", 32'(alu_op1), 32'(e_op1));
            chk("m_op2", 32'(alu_op2), 32'(e_op2));
            chk("m_immx", 32'(alu_immx), 32'(e_immx));
            chk("m_isimm", 32'(alu_isimmediate), 32'(e_isimm));
        end
        if (reset) begin
            exp_q.delete();
            m_ptr = 1'b0; e_sig = '0; e_op1 = '0; e_op2 = '0; e_immx = '0; e_isimm = 1'b0;
            m_en = 1'b1;
        end else if (flush) begin
            exp_q.delete();
            e_sig = '0;
        end else begin
            if (at_done) begin
                void'(exp_q.pop_front());
                e_sig = '0;
            end
            if (e_rdy != 2'b00) begin
                ln      = e_rdy[1];
                s       = ln ? req_alusignals1 : req_alusignals0;
                e_sig   = s;
                e_op1   = ln ? req_op1_1 : req_op1_0;
                e_op2   = ln ? req_op2_1 : req_op2_0;
                e_immx  = ln ? req_immx1 : req_immx0;
                e_isimm = ln ? req_isimm1 : req_isimm0;
                exp_q.push_back({ln, ln ? req_tag1 : req_tag0,
                                 alu_fn(s, e_op1, e_op2, e_immx, e_isimm)});
                done_cyc = cyc + 1 + ((s == 13'h0010) ? MUL_LAT : ALU_LAT);
                m_ptr    = ~ln;
            end
        end
        cyc++;
    endtask

    typedef struct {
        logic rst, fl;
        logic [1:0] rv;
        logic [12:0] s0; logic [3:0] t0;
        logic [12:0] s1; logic [3:0] t1;
        logic [1:0] e_rdy, e_rv;
        logic [15:0] e_res; logic [3:0] e_tag;
        logic [12:0] e_sig; logic [15:0] e_op1;
    } vec_t;
    vec_t tbl[$];

    function automatic void row(input logic rst, input logic fl, input logic [1:0] rv,
                                input logic [12:0] s0, input logic [3:0] t0,
                                input logic [12:0] s1, input logic [3:0] t1,
                                input logic [1:0] e_rdy, input logic [1:0] e_rv,
                                input logic [15:0] e_res, input logic [3:0] e_tag,
                                input logic [12:0] e_sig, input logic [15:0] e_op1);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rv = rv; v.s0 = s0; v.t0 = t0; v.s1 = s1; v.t1 = t1;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_res = e_res; v.e_tag = e_tag;
        v.e_sig = e_sig; v.e_op1 = e_op1;
        tbl.push_back(v);
    endfunction

    task automatic rand_sig(output logic [12:0] s);
        case ($urandom_range(0, 12))
            0: s = 13'h0001;  1: s = 13'h0008;  2: s = 13'h0010;  3: s = 13'h0020;
            4: s = 13'h0040;  5: s = 13'h0080;  6: s = 13'h0100;  7: s = 13'h0200;
            8: s = 13'h0400;  9: s = 13'h0800; 10: s = 13'h0000; 11: s = 13'h0011;
            default: s = 13'($urandom);
        endcase
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = 2'b00;
        req_alusignals0 = '0; req_alusignals1 = '0;
        req_op1_0 = 16'd5; req_op1_1 = 16'd5; req_op2_0 = 16'd3; req_op2_1 = 16'd3;
        req_immx0 = '0; req_immx1 = '0; req_isimm0 = 1'b0; req_isimm1 = 1'b0;
        req_tag0 = '0; req_tag1 = '0;

        // Dual requests, pointer at lane 0: SUB 5-3 (tag 4) vs OR 5|3 (tag 5)
        row(0,0,2'b11,13'h008,4,13'h080,5, 2'b01,2'b00,16'h0,0, 13'h000,16'h0);
        row(0,0,2'b11,13'h008,4,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h008,16'h5);
        row(0,0,2'b11,13'h008,4,13'h080,5, 2'b10,2'b01,16'h2,4, 13'h008,16'h5);
        row(0,0,2'b11,13'h008,4,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h080,16'h5);
        row(0,0,2'b11,13'h008,4,13'h080,5, 2'b01,2'b10,16'h7,5, 13'h080,16'h5);
        row(0,0,2'b11,13'h008,4,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h008,16'h5);
        row(0,0,2'b11,13'h008,4,13'h080,5, 2'b10,2'b01,16'h2,4, 13'h008,16'h5);
        row(0,0,2'b00,13'h008,4,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h080,16'h5);
        row(0,0,2'b00,13'h008,4,13'h080,5, 2'b00,2'b10,16'h7,5, 13'h080,16'h5);
        row(0,0,2'b00,13'h008,4,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h000,16'h5);
        // Lane0 ADD 5+3 tag 2
        row(0,0,2'b01,13'h001,2,13'h000,0, 2'b01,2'b00,16'h0,0, 13'h000,16'h5);
        row(0,0,2'b00,13'h001,2,13'h000,0, 2'b00,2'b00,16'h0,0, 13'h001,16'h5);
        row(0,0,2'b00,13'h001,2,13'h000,0, 2'b00,2'b01,16'h8,2, 13'h001,16'h5);
        row(0,0,2'b00,13'h001,2,13'h000,0, 2'b00,2'b00,16'h0,0, 13'h000,16'h5);
        // Lane1 MUL tag 7, lane0 waits and is taken in the completion cycle
        row(0,0,2'b10,13'h001,2,13'h010,7, 2'b10,2'b00,16'h0,0, 13'h000,16'h5);
        row(0,0,2'b01,13'h001,2,13'h010,7, 2'b00,2'b00,16'h0,0, 13'h010,16'h5);
        row(0,0,2'b01,13'h001,2,13'h010,7, 2'b00,2'b00,16'h0,0, 13'h010,16'h5);
        row(0,0,2'b01,13'h001,2,13'h010,7, 2'b00,2'b00,16'h0,0, 13'h010,16'h5);
        row(0,0,2'b01,13'h001,2,13'h010,7, 2'b01,2'b10,16'hf,7, 13'h010,16'h5);
        row(0,0,2'b00,13'h001,2,13'h010,7, 2'b00,2'b00,16'h0,0, 13'h001,16'h5);
        row(0,0,2'b00,13'h001,2,13'h010,7, 2'b00,2'b01,16'h8,2, 13'h001,16'h5);
        row(0,0,2'b00,13'h001,2,13'h010,7, 2'b00,2'b00,16'h0,0, 13'h000,16'h5);
        // Flush during lane1 MUL tag 9; lane0 request blocked in the flush cycle
        row(0,0,2'b10,13'h001,2,13'h010,9, 2'b10,2'b00,16'h0,0, 13'h000,16'h5);
        row(0,0,2'b00,13'h001,2,13'h010,9, 2'b00,2'b00,16'h0,0, 13'h010,16'h5);
        row(0,1,2'b01,13'h001,2,13'h010,9, 2'b00,2'b00,16'h0,0, 13'h010,16'h5);
        row(0,0,2'b01,13'h001,2,13'h010,9, 2'b01,2'b00,16'h0,0, 13'h000,16'h5);
        row(0,0,2'b00,13'h001,2,13'h010,9, 2'b00,2'b00,16'h0,0, 13'h001,16'h5);
        row(0,0,2'b00,13'h001,2,13'h010,9, 2'b00,2'b01,16'h8,2, 13'h001,16'h5);
        row(0,0,2'b00,13'h001,2,13'h010,9, 2'b00,2'b00,16'h0,0, 13'h000,16'h5);
        // Lane0 MUL moves pointer to lane1; reset+flush mid-EXEC restores lane0 priority
        row(0,0,2'b01,13'h010,9,13'h080,5, 2'b01,2'b00,16'h0,0, 13'h000,16'h5);
        row(0,0,2'b00,13'h010,9,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h010,16'h5);
        row(1,1,2'b11,13'h010,9,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h010,16'h5);
        row(0,0,2'b11,13'h001,2,13'h080,5, 2'b01,2'b00,16'h0,0, 13'h000,16'h0);
        row(0,0,2'b00,13'h001,2,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h001,16'h5);
        row(0,0,2'b00,13'h001,2,13'h080,5, 2'b00,2'b01,16'h8,2, 13'h001,16'h5);
        row(0,0,2'b00,13'h001,2,13'h080,5, 2'b00,2'b00,16'h0,0, 13'h000,16'h5);

        for (int i = 0; i < 2; i++) begin
            #4;
            step_model();
            @(posedge clk); #1;
        end
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; flush = tbl[i].fl; req_valid = tbl[i].rv;
            req_alusignals0 = tbl[i].s0; req_tag0 = tbl[i].t0;
            req_alusignals1 = tbl[i].s1; req_tag1 = tbl[i].t1;
            req_op1_0 = 16'd5; req_op1_1 = 16'd5; req_op2_0 = 16'd3; req_op2_1 = 16'd3;
            req_immx0 = '0; req_immx1 = '0; req_isimm0 = 1'b0; req_isimm1 = 1'b0;
            #4;
            chk($sformatf("t%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("t%0d_resp_valid", i), 32'(resp_valid), 32'(tbl[i].e_rv));
            chk($sformatf("t%0d_resp_result", i), 32'(resp_result), 32'(tbl[i].e_res));
            chk($sformatf("t%0d_resp_tag", i), 32'(resp_tag), 32'(tbl[i].e_tag));
            chk($sformatf("t%0d_alusig", i), 32'(alu_alusignals), 32'(tbl[i].e_sig));
            chk($sformatf("t%0d_op1", i), 32'(alu_op1), 32'(tbl[i].e_op1));
            step_model();
            @(posedge clk); #1;
        end

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 11) == 0);
            req_valid = 2'($urandom);
            rand_sig(req_alusignals0);
            rand_sig(req_alusignals1);
            req_op1_0 = 16'($urandom); req_op1_1 = 16'($urandom);
            req_op2_0 = 16'($urandom); req_op2_1 = 16'($urandom);
            req_immx0 = 5'($urandom); req_immx1 = 5'($urandom);
            req_isimm0 = 1'($urandom); req_isimm1 = 1'($urandom);
            req_tag0 = 4'($urandom); req_tag1 = 4'($urandom);
            #4;
            step_model();
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
